sieben_segment_anzeige: RTL and testbench

- Two-digit seven-segment display driver.
- Takes a 4-bit value `in` and a mode switch `sw`, and drives two active-low 7-segment patterns:
  - `out0`: right/units digit.
  - `out1`: left/tens digit.
- `sw=0` selects hexadecimal display (single digit 0–F); `sw=1` selects decimal display (00–15).
- Outputs are registered; the block sits between switch/counter logic and the board's segment pins.

---
 rtl/seven_seg_pkg.sv | 31 +++
 rtl/seg7_decoder.sv | 32 +++
 rtl/sieben_segment_anzeige.sv | 62 ++++++
 tb/tb_sieben_segment_anzeige.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment encodings and digit type for the two-digit seven-segment driver.
// Codes are active-low, bit6=a ... bit0=g.
package seven_seg_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [SEG_W-1:0]   seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam digit_t DECIMAL_BASE = 4'd10;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit digit to active-low seven-segment pattern decoder.
module seg7_decoder
  import seven_seg_pkg::*;
(
  input  digit_t digit,
  output seg_t   seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sieben_segment_anzeige.sv
// Two-digit seven-segment driver: hex on the units digit, or decimal 00-15 across both.
// Reset input is active-high despite its name.
module sieben_segment_anzeige
  import seven_seg_pkg::*;
#(
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DIGIT_W-1:0] in,
  input  logic               sw,
  output logic [SEG_W-1:0]   out0,
  output logic [SEG_W-1:0]   out1
);

  logic   ge_ten_c;
  digit_t units_c;
  digit_t tens_c;
  seg_t   units_seg_c;
  seg_t   tens_seg_c;
  seg_t   next_out0_c;
  seg_t   next_out1_c;

  // Binary-to-BCD split; only applied in decimal mode
  always_comb begin
    ge_ten_c = sw && (in >= DECIMAL_BASE);
    units_c  = ge_ten_c ? DIGIT_W'(in - DECIMAL_BASE) : in;
    tens_c   = ge_ten_c ? DIGIT_W'(1) : DIGIT_W'(0);
  end

  seg7_decoder u_units (
    .digit (units_c),
    .seg   (units_seg_c)
  );

  seg7_decoder u_tens (
    .digit (tens_c),
    .seg   (tens_seg_c)
  );

  // Mode mux and leading-zero blanking
  always_comb begin
    next_out0_c = units_seg_c;
    next_out1_c = SEG_BLANK;
    if (sw) begin
      if (ge_ten_c || !BLANK_LEADING_ZERO) begin
        next_out1_c = tens_seg_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      out0 <= SEG_BLANK;
      out1 <= SEG_BLANK;
    end else begin
      out0 <= next_out0_c;
      out1 <= next_out1_c;
    end
  end

endmodule

// File: tb/tb_sieben_segment_anzeige.sv
// Directed self-checking bench for sieben_segment_anzeige (default and leading-zero variants).
module tb_sieben_segment_anzeige;

  logic       clk;
  logic       reset_n;
  logic [3:0] in;
  logic       sw;
  logic [6:0] out0;
  logic [6:0] out1;
  logic [6:0] z_out0;
  logic [6:0] z_out1;

  int checks;
  int errors;

  localparam logic [6:0] BLANK = 7'b1111111;

  sieben_segment_anzeige dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .sw      (sw),
    .out0    (out0),
    .out1    (out1)
  );

  sieben_segment_anzeige #(.BLANK_LEADING_ZERO(1'b0)) dut_z (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .sw      (sw),
    .out0    (z_out0),
    .out1    (z_out1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-written segment table, independent of the RTL package
  function automatic logic [6:0] code(input int v);
    case (v)
      0:  code = 7'b0000001;
      1:  code = 7'b1001111;
      2:  code = 7'b0010010;
      3:  code = 7'b0000110;
      4:  code = 7'b1001100;
      5:  code = 7'b0100100;
      6:  code = 7'b0100000;
      7:  code = 7'b0001111;
      8:  code = 7'b0000000;
      9:  code = 7'b0000100;
      10: code = 7'b0001000;
      11: code = 7'b1100000;
      12: code = 7'b0110001;
      13: code = 7'b1000010;
      14: code = 7'b0110000;
      15: code = 7'b0111000;
      default: code = 7'b1111111;
    endcase
  endfunction

  task automatic test_reset;
    reset_n = 1'b1;
    in = 4'd0;
    sw = 1'b0;
    #50;
    checks++;
    if (out0 !== BLANK || out1 !== BLANK) begin
      errors++;
      $display("FAIL reset: out1=%b out0=%b expected %b %b", out1, out0, BLANK, BLANK);
    end
    @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic test_hex_sweep;
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      sw = 1'b0;
      in = 4'(v);
      repeat (10) @(negedge clk);
      checks++;
      if (out0 !== code(v) || out1 !== BLANK) begin
        errors++;
        $display("FAIL hex_%0d: out1=%b out0=%b expected %b %b", v, out1, out0, BLANK, code(v));
      end
    end
  endtask

  task automatic test_decimal_sweep;
    logic [6:0] e0, e1, ez1;
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      sw = 1'b1;
      in = 4'(v);
      @(posedge clk);
      #1;
      e0  = (v >= 10) ? code(v - 10) : code(v);
      e1  = (v >= 10) ? code(1) : BLANK;
      ez1 = (v >= 10) ? code(1) : code(0);
      checks++;
      if (out0 !== e0 || out1 !== e1) begin
        errors++;
        $display("FAIL dec_%0d: out1=%b out0=%b expected %b %b", v, out1, out0, e1, e0);
      end
      checks++;
      if (z_out0 !== e0 || z_out1 !== ez1) begin
        errors++;
        $display("FAIL dec_zero_%0d: out1=%b out0=%b expected %b %b", v, z_out1, z_out0, ez1, e0);
      end
    end
  endtask

  // 9 -> 10 must flip both digits on the same edge
  task automatic test_back_to_back;
    @(negedge clk);
    sw = 1'b1;
    in = 4'd9;
    @(posedge clk);
    #1;
    in = 4'd10;
    checks++;
    if (out0 !== 7'b0000100 || out1 !== BLANK) begin
      errors++;
      $display("FAIL b2b_9: out1=%b out0=%b expected %b %b", out1, out0, BLANK, 7'b0000100);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out0 !== 7'b0000001 || out1 !== 7'b1001111) begin
      errors++;
      $display("FAIL b2b_10: out1=%b out0=%b expected %b %b", out1, out0, 7'b1001111, 7'b0000001);
    end
  endtask

  task automatic test_mode_switch;
    @(negedge clk);
    sw = 1'b0;
    in = 4'd12;
    @(posedge clk);
    #1;
    checks++;
    if (out0 !== 7'b0110001 || out1 !== BLANK) begin
      errors++;
      $display("FAIL mode_hex: out1=%b out0=%b expected %b %b", out1, out0, BLANK, 7'b0110001);
    end
    @(negedge clk);
    sw = 1'b1;
    #1;
    checks++;
    if (out0 !== 7'b0110001 || out1 !== BLANK) begin
      errors++;
      $display("FAIL mode_hold: out1=%b out0=%b expected %b %b", out1, out0, BLANK, 7'b0110001);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out0 !== 7'b0010010 || out1 !== 7'b1001111) begin
      errors++;
      $display("FAIL mode_dec: out1=%b out0=%b expected %b %b", out1, out0, 7'b1001111, 7'b0010010);
    end
  endtask

  task automatic test_latency;
    @(negedge clk);
    sw = 1'b1;
    in = 4'd7;
    @(posedge clk);
    @(negedge clk);
    in = 4'd14;
    #2;
    checks++;
    if (out0 !== 7'b0001111 || out1 !== BLANK) begin
      errors++;
      $display("FAIL latency_hold: out1=%b out0=%b expected %b %b", out1, out0, BLANK, 7'b0001111);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out0 !== 7'b1001100 || out1 !== 7'b1001111) begin
      errors++;
      $display("FAIL latency_update: out1=%b out0=%b expected %b %b", out1, out0, 7'b1001111, 7'b1001100);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    sw = 1'b1;
    in = 4'd13;
    @(posedge clk);
    #1;
    checks++;
    if (out0 !== 7'b0000110 || out1 !== 7'b1001111) begin
      errors++;
      $display("FAIL pre_reset_13: out1=%b out0=%b expected %b %b", out1, out0, 7'b1001111, 7'b0000110);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    checks++;
    if (out0 !== BLANK || out1 !== BLANK) begin
      errors++;
      $display("FAIL async_reset: out1=%b out0=%b expected %b %b", out1, out0, BLANK, BLANK);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out0 !== BLANK || out1 !== BLANK) begin
      errors++;
      $display("FAIL reset_held: out1=%b out0=%b expected %b %b", out1, out0, BLANK, BLANK);
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out0 !== 7'b0000110 || out1 !== 7'b1001111) begin
      errors++;
      $display("FAIL post_reset_13: out1=%b out0=%b expected %b %b", out1, out0, 7'b1001111, 7'b0000110);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hex_sweep();
    test_decimal_sweep();
    test_back_to_back();
    test_mode_switch();
    test_latency();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
